// File: rtl/clk_div_pkg.sv
// Shared constants and the half-period helper for the programmable 50% duty divider.
// Imported by clk_div_n; the negedge flop needs none of it.
package clk_div_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int MIN_DIV   = 2;

  typedef struct packed {
    logic [31:0] half;  // floor(N/2)
    logic        odd;   // N is odd, so the half-cycle stretch flop is needed
  } half_t;

  function automatic half_t half_period(input logic [31:0] n);
    half_t r;
    r.half = {1'b0, n[31:1]};
    r.odd  = n[0];
    return r;
  endfunction

endpackage

// File: rtl/clk_div_negff.sv
// Single-bit falling-edge flop with synchronous active-high clear.
// It stretches the divided clock by half an input cycle for odd divisors.
module clk_div_negff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(negedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/clk_div_n.sv
// Runtime-programmable integer clock divider, exact 50% duty for odd and even N,
// with a wrap-aligned divisor reload, run enable and a once-per-period tick.
module clk_div_n
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_err,
  output logic [WIDTH-1:0] div_active,
  output logic [WIDTH-1:0] ph,
  output logic             tick,
  output logic             f
);

  localparam logic [WIDTH-1:0] RST_DIV   = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_DIV_W = WIDTH'(MIN_DIV);

  // Load handshake: div_load is a one-cycle request with no ready; a legal div_in
  // is held in the pending register (last request wins) until the next period wrap,
  // or the next posedge when idle, where div_ack pulses; an illegal one pulses div_err.

  logic             f_p;
  logic             f_n;
  logic             pend;
  logic [WIDTH-1:0] pend_div;
  logic [WIDTH-1:0] last_ph;
  logic [WIDTH-1:0] ph_next;
  logic [WIDTH-1:0] new_last;
  logic             at_wrap;
  logic             load_ok;
  logic             load_bad;
  logic             apply;
  half_t            cur_h;

  always_comb begin
    cur_h    = half_period(32'(div_active));
    last_ph  = div_active - ONE;
    at_wrap  = (ph == last_ph);
    ph_next  = at_wrap ? '0 : ph + ONE;
    load_ok  = div_load && (div_in >= MIN_DIV_W);
    load_bad = div_load && !load_ok;
    apply    = pend && (at_wrap || !en);
    new_last = pend_div - ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_active <= RST_DIV;
      ph         <= RST_DIV - ONE;
      f_p        <= 1'b0;
      tick       <= 1'b0;
      div_ack    <= 1'b0;
      div_err    <= 1'b0;
      pend       <= 1'b0;
      pend_div   <= RST_DIV;
    end else begin
      div_ack <= apply;
      div_err <= load_bad;
      if (apply) begin
        div_active <= pend_div;
        pend       <= 1'b0;
        tick       <= 1'b0;
        if (en) begin
          // First cycle of the new period; 0 < floor(N/2) for every legal N.
          ph  <= '0;
          f_p <= 1'b1;
        end else begin
          ph  <= new_last;
          f_p <= 1'b0;
        end
      end else if (en) begin
        ph   <= ph_next;
        f_p  <= (32'(ph_next) < cur_h.half);
        tick <= (ph_next == last_ph);
      end else begin
        ph   <= last_ph;
        f_p  <= 1'b0;
        tick <= 1'b0;
      end
      // A request landing on the apply edge survives as the next pending value.
      if (load_ok) begin
        pend     <= 1'b1;
        pend_div <= div_in;
      end
    end
  end

  clk_div_negff u_negff (
    .clk (clk),
    .rst (rst),
    .d   (f_p & cur_h.odd),
    .q   (f_n)
  );

  assign f = f_p | f_n;

endmodule

// File: tb/tb_clk_div_n.sv
// Scoreboard bench for clk_div_n: directed loads, enables and resets queue the
// expected ack/err/tick/idle/run events; a monitor measures f and compares.
module tb_clk_div_n;

  localparam int W     = 8;
  localparam int OBS_W = 43;
  localparam logic [2:0] K_ACK  = 3'd0;
  localparam logic [2:0] K_ERR  = 3'd1;
  localparam logic [2:0] K_TICK = 3'd2;
  localparam logic [2:0] K_IDLE = 3'd3;
  localparam logic [2:0] K_RUN  = 3'd4;

  // ---------------- clock / reset ----------------
  logic         clk      = 1'b0;
  logic         rst      = 1'b1;
  logic         en       = 1'b0;
  logic         div_load = 1'b0;
  logic [W-1:0] div_in   = '0;
  logic         div_ack;
  logic         div_err;
  logic         tick;
  logic         f;
  logic [W-1:0] div_active;
  logic [W-1:0] ph;

  always #5 clk = ~clk;

  clk_div_n #(.WIDTH(W), .DEFAULT_DIV(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .div_in     (div_in),
    .div_load   (div_load),
    .div_ack    (div_ack),
    .div_err    (div_err),
    .div_active (div_active),
    .ph         (ph),
    .tick       (tick),
    .f          (f)
  );

  // ---------------- scoreboard ----------------
  logic [OBS_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int n_obs = 0;

  function automatic logic [OBS_W-1:0] mk(input logic [2:0] k, input logic [31:0] d,
                                          input logic [31:0] p, input logic [31:0] h,
                                          input logic [31:0] t);
    return {k, d[7:0], p[7:0], h[11:0], t[11:0]};
  endfunction

  function automatic string fmt(input logic [OBS_W-1:0] v);
    return $sformatf("kind=%0d div=%0d ph=%0d hi=%0d tot=%0d",
                     v[42:40], v[39:32], v[31:24], v[23:12], v[11:0]);
  endfunction

  // Full period of divisor n: hi counts high half-cycles, tot all half-cycles.
  task automatic exp_tick(input int n);
    exp_q.push_back(mk(K_TICK, n, n - 1, n, 2 * n));
  endtask

  task automatic see(input logic [2:0] k, input logic [31:0] d, input logic [31:0] p,
                     input logic [31:0] h, input logic [31:0] t);
    logic [OBS_W-1:0] got;
    logic [OBS_W-1:0] want;
    got = mk(k, d, p, h, t);
    n_vec++;
    n_obs++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL obs%0d unexpected: got %s", n_obs, fmt(got));
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        n_bad++;
        $display("FAIL obs%0d: got %s, want %s", n_obs, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // ---------------- monitor ----------------
  bit mon_on    = 1'b0;
  bit prev_idle = 1'b1;
  bit idle_a    = 1'b1;
  bit tick_a    = 1'b0;
  int hi_cnt    = 0;
  int tot_cnt   = 0;

  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      idle_a = (ph == 8'(div_active - 8'd1)) && (tick == 1'b0);
      if (idle_a && !prev_idle) see(K_IDLE, div_active, ph, {31'd0, f}, 0);
      if (!idle_a && prev_idle) see(K_RUN, div_active, ph, {31'd0, f}, 0);
      prev_idle = idle_a;
      if (div_ack) see(K_ACK, div_active, ph, 0, 0);
      if (div_err) see(K_ERR, div_active, ph, 0, 0);
      if (idle_a) begin
        hi_cnt  = 0;
        tot_cnt = 0;
      end else begin
        if (f) hi_cnt++;
        tot_cnt++;
      end
      tick_a = tick;
    end
  end

  always @(negedge clk) begin
    #1;
    if (mon_on && !idle_a) begin
      if (f) hi_cnt++;
      tot_cnt++;
      if (tick_a) begin
        see(K_TICK, div_active, ph, hi_cnt, tot_cnt);
        hi_cnt  = 0;
        tot_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [W-1:0] v);
    div_load = 1'b1;
    div_in   = v;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".div_active"}, div_active, 5);
    check({tag, ".ph"},         ph,         4);
    check({tag, ".f"},          f,          0);
    check({tag, ".tick"},       tick,       0);
    check({tag, ".div_ack"},    div_ack,    0);
    check({tag, ".div_err"},    div_err,    0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d expected events left", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    cyc(3);
    check_reset_state("rst0");
    rst    = 1'b0;
    mon_on = 1'b1;

    // Default N=5: f rises on the first enabled edge, 2.5 high / 2.5 low.
    exp_q.push_back(mk(K_RUN, 5, 0, 1, 0));
    repeat (3) exp_tick(5);
    en = 1'b1;
    cyc(15);

    // Illegal divisors 1 then 0: two errors, N=5 untouched.
    exp_q.push_back(mk(K_ERR, 5, 2, 0, 0));
    exp_q.push_back(mk(K_ERR, 5, 3, 0, 0));
    exp_tick(5);
    cyc(2);
    load(8'd1);
    cyc(1);
    div_in = 8'd0;
    cyc(1);
    div_load = 1'b0;
    cyc(1);

    // Load 4 at ph=1: current 5-period completes, then clean 2/2 periods.
    exp_tick(5);
    exp_q.push_back(mk(K_ACK, 4, 0, 0, 0));
    repeat (2) exp_tick(4);
    cyc(2);
    load(8'd4);
    cyc(1);
    div_load = 1'b0;
    cyc(10);

    // Load 7 then 9 back to back: only 9 applies; then a load on the wrap edge.
    exp_tick(4);
    exp_q.push_back(mk(K_ACK, 9, 0, 0, 0));
    repeat (2) exp_tick(9);
    exp_q.push_back(mk(K_ACK, 3, 0, 0, 0));
    exp_tick(3);
    exp_q.push_back(mk(K_ACK, 6, 0, 0, 0));
    cyc(2);
    load(8'd7);
    cyc(1);
    div_in = 8'd9;
    cyc(1);
    div_load = 1'b0;
    cyc(17);
    load(8'd3);
    cyc(1);
    div_in = 8'd6;
    cyc(1);
    div_load = 1'b0;

    // N=6: drop en at ph=2, truncate, resume with ph=0 and f high at once.
    exp_q.push_back(mk(K_IDLE, 6, 5, 0, 0));
    exp_q.push_back(mk(K_RUN, 6, 0, 1, 0));
    exp_tick(6);
    cyc(5);
    en = 1'b0;
    cyc(2);
    en = 1'b1;

    // Reset at ph=3 with a load pending: back to N=5, no ack ever appears.
    exp_q.push_back(mk(K_IDLE, 5, 4, 0, 0));
    exp_q.push_back(mk(K_RUN, 5, 0, 1, 0));
    repeat (2) exp_tick(5);
    cyc(7);
    load(8'd3);
    cyc(1);
    div_load = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    check_reset_state("rst_mid");
    rst = 1'b0;
    cyc(10);
    cyc(2);

    mon_on = 1'b0;
    while (exp_q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL missing event: want %s", fmt(exp_q.pop_front()));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_div_n.md
Name: clk_div_n

Overview:
- Runtime-programmable integer clock divider with exact 50% duty cycle for both odd and even divisors.
- Generalises the team's fixed divide-by-5 block to any divisor 2..2^WIDTH-1.
- Adds a glitch-free divisor reload handshake, an enable, and a once-per-period tick.
- Feeds baud, strobe and sampling-enable generation in the same clock domain.

Parameters:
WIDTH, 8, bit width of divisor and phase counter
DEFAULT_DIV, 5, divisor loaded at reset; must satisfy 2 <= DEFAULT_DIV <= 2^WIDTH-1

Ports:
clk  input  1  single clock; posedge logic plus one negedge half-cycle flop
rst  input  1  synchronous, active-high reset
en  input  1  run enable, level-sensitive
div_in  input  WIDTH  requested divisor N
div_load  input  1  one-cycle request to load div_in
div_ack  output  1  one-cycle pulse when the pending divisor becomes active
div_err  output  1  one-cycle pulse when a load is rejected (div_in < 2)
div_active  output  WIDTH  divisor currently in use
ph  output  WIDTH  phase counter, 0..N-1
tick  output  1  one-cycle pulse in the last cycle of each output period
f  output  1  divided clock, 50% duty

Behaviour:
- Reset is synchronous, active-high, sampled at posedge clk; the negedge flop also clears synchronously.
- Reset values:
  - div_active=DEFAULT_DIV, ph=DEFAULT_DIV-1.
  - f_p=0, f_n=0, f=0, tick=0, div_ack=0, div_err=0.
  - pending flag=0.
- Rst mid-period: the next posedge forces all of the above, and any pending load is discarded.
- Definitions: N=div_active; H=floor(N/2); ph_next=(ph==N-1)?0:ph+1.
- Idle (en=0): ph holds N-1; f_p forced to 0 at the next posedge; tick=0.
- Run (en=1), each posedge:
  - ph<=ph_next.
  - f_p<=(ph_next<H).
  - tick<=(ph_next==N-1).
- First enabled posedge: ph goes 0 and f rises. There is no extra latency.
- Duty cycle:
  - Even N: f=f_p, giving H cycles high and H cycles low.
  - Odd N: f_n samples f_p on negedge clk; f=f_p|f_n. High time is H+0.5 cycles, low time is H+0.5 cycles.
  - Even N: f_n is forced to 0.
- Load handshake:
  - div_load=1 with div_in>=2: capture into the pending register and set pending. A second load while pending overwrites it with the last value.
  - div_load=1 with div_in<2: div_err pulses next cycle; pending and active values are untouched.
- Apply point:
  - Running: the posedge where ph==N-1 (period wrap). div_active<=pending, ph<=0, f_p<=(0<H_new), pending cleared, div_ack pulses that same cycle.
  - Idle: apply at the next posedge; ph<=N_new-1; div_ack pulses.
- Load and apply in the same cycle: the apply uses the old pending value. The new request becomes pending for the next wrap.
- No partial or runt periods are permitted on f at any divisor change.
- en deassert mid-period: the period is truncated. f falls at the next posedge (odd N: f_n drops at the following negedge). ph returns to N-1.
- ph width: ph is compared against N-1 in WIDTH bits, so no overflow is possible for N<=2^WIDTH-1.
- Outputs are registered except f (an OR of two flops). f is used as a clock-enable or source only through the team's clock-mux cell.

Decomposition:
- Package clk_div_pkg holds:
  - the WIDTH default;
  - MIN_DIV=2;
  - a half-period helper function (floor(N/2) and an odd flag).
- Sub-module clk_div_negff: a 1-bit negedge flop with synchronous active-high reset, producing f_n.
- All other logic stays in clk_div_n.

Test Plan:
1. Reset, en=1, DEFAULT_DIV=5 -> f has period 5 clk with high time exactly 2.5 clk; tick once every 5 cycles at ph=4.
2. Load div_in=4 mid-period -> div_ack at the ph=4 wrap; next period is 4 clk with f high for 2, low for 2; no runt pulse.
3. Load div_in=1, then div_in=0 -> div_err pulses each time; div_active stays 5 and the f waveform is unchanged.
4. Load 7 then 9 in consecutive cycles before the wrap -> only 9 is applied; a single div_ack; period 9 with 4.5 high / 4.5 low.
5. en=0 at ph=2 with N=6 -> f low at the next posedge, ph=5; en=1 again -> f rises on the first enabled posedge and ph=0.
6. rst asserted at ph=3 with a load pending -> next posedge shows ph=DEFAULT_DIV-1, f=0, pending dropped and no div_ack.
